// File: rtl/reset_sequencer.sv
// Staged reset release controller: waits for PLL lock, then releases stage_rst_n[0..NUM_STAGES-1]
// one at a time, DELAY_CYCLES apart. Lock-to-done latency is 2 + NUM_STAGES*DELAY_CYCLES edges; abort is 1 edge.
// No backpressure: soft_rst_req (and, with RESET_SEQ_LOCK_MONITOR_EN defined, loss of lock) re-arms the sequence.
//
// Optional feature macro: RESET_SEQ_LOCK_MONITOR_EN
//   defined   : lock loss while counting or done aborts exactly like soft_rst_req
//   undefined : lock is only looked at while waiting for the initial lock

module reset_sequencer #(
    parameter int NUM_STAGES   = 4,
    parameter int DELAY_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  done
);

    // Counter and stage index are never narrower than one bit so the
    // degenerate configurations (one stage, one-cycle delay) stay legal.
    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int K_W   = (NUM_STAGES > 1)   ? $clog2(NUM_STAGES)   : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [K_W-1:0]        K_LAST    = K_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [K_W-1:0]        K_ONE     = K_W'(1);
    localparam logic [NUM_STAGES-1:0] STAGE_LSB = NUM_STAGES'(1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_COUNT     = 2'd1;
    localparam logic [1:0] ST_DONE      = 2'd2;

    // Registered state
    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [K_W-1:0]        k;
    logic                  lock_meta;
    logic                  lock_s;

    // Next-state values
    logic [1:0]            state_d;
    logic [CNT_W-1:0]      cnt_d;
    logic [K_W-1:0]        k_d;
    logic [NUM_STAGES-1:0] stage_rst_n_d;
    logic                  done_d;

    // Decoded conditions
    logic                  in_seq;
    logic                  abort_req;
    logic                  abort;
    logic                  term_cnt;
    logic                  last_stage;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Abort / terminal-count decode shared by the next-state logic.
    always_comb begin
        in_seq    = (state == ST_COUNT) || (state == ST_DONE);
`ifdef RESET_SEQ_LOCK_MONITOR_EN
        // A simultaneous soft request and lock loss still yields a single abort.
        abort_req = soft_rst_req || !lock_s;
`else
        abort_req = soft_rst_req;
`endif
        abort      = in_seq && abort_req;
        term_cnt   = (state == ST_COUNT) && (cnt == CNT_LAST);
        last_stage = (k == K_LAST);
    end

    // Next-state logic: abort has priority over any release on the same edge.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        k_d           = k;
        stage_rst_n_d = stage_rst_n;
        done_d        = done;

        if (abort) begin
            state_d       = ST_WAIT_LOCK;
            cnt_d         = '0;
            k_d           = '0;
            stage_rst_n_d = '0;
            done_d        = 1'b0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    stage_rst_n_d = '0;
                    done_d        = 1'b0;
                    cnt_d         = '0;
                    k_d           = '0;
                    if (!soft_rst_req && lock_s) begin
                        state_d = ST_COUNT;
                    end
                end

                ST_COUNT: begin
                    if (term_cnt) begin
                        // Released bits are always a contiguous run from bit 0,
                        // so releasing bit k is the same as shifting in a one.
                        stage_rst_n_d = (stage_rst_n << 1) | STAGE_LSB;
                        cnt_d         = '0;
                        k_d           = k + K_ONE;
                        if (last_stage) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end

                ST_DONE: begin
                    // Everything held released; counter parked.
                    cnt_d = cnt;
                end

                default: begin
                    // Unreachable encoding: fall back to a full re-sequence.
                    state_d       = ST_WAIT_LOCK;
                    cnt_d         = '0;
                    k_d           = '0;
                    stage_rst_n_d = '0;
                    done_d        = 1'b0;
                end
            endcase
        end
    end

    // Sequencer registers, including the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_WAIT_LOCK;
            cnt         <= '0;
            k           <= '0;
            stage_rst_n <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            k           <= k_d;
            stage_rst_n <= stage_rst_n_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two configurations (3 stages x 4 cycles, 2 stages x 1 cycle)
// driven by shared directed then random stimulus and compared against an edge-count reference model.
// Outputs are sampled on the falling edge or 1 ns after the rising edge.

module tb_reset_sequencer;

    localparam int N1 = 3;
    localparam int D1 = 4;
    localparam int N2 = 2;
    localparam int D2 = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          soft_rst_req;
    logic [N1-1:0] s1;
    logic          d1;
    logic [N2-1:0] s2;
    logic          d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_STAGES(N1), .DELAY_CYCLES(D1)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .stage_rst_n  (s1),
        .done         (d1)
    );

    reset_sequencer #(.NUM_STAGES(N2), .DELAY_CYCLES(D2)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .stage_rst_n  (s2),
        .done         (d2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the sequence is described only by the edge number at
    // which it started (e0, -1 while waiting). The released count follows from
    // elapsed edges divided by the delay, saturated at the stage count.
    int edge_no = 0;
    int e0      = -1;
    bit l1      = 1'b0;
    bit l2      = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e0 = -1;
            l1 = 1'b0;
            l2 = 1'b0;
        end else begin
            bit ls;
            bit ab;
            edge_no++;
            ls = l2;
            l2 = l1;
            l1 = pll_locked;
            if (e0 < 0) begin
                if (!soft_rst_req && ls) e0 = edge_no;
            end else begin
                ab = soft_rst_req;
`ifdef RESET_SEQ_LOCK_MONITOR_EN
                if (!ls) ab = 1'b1;
`endif
                if (ab) e0 = -1;
            end
        end
    end

    function automatic logic [31:0] exp_mask(input int n, input int d);
        int rel;
        if (e0 < 0) return 32'd0;
        rel = (edge_no - e0) / d;
        if (rel > n) rel = n;
        return (32'd1 << rel) - 32'd1;
    endfunction

    function automatic logic [31:0] exp_done(input int n, input int d);
        return (exp_mask(n, d) == ((32'd1 << n) - 32'd1)) ? 32'd1 : 32'd0;
    endfunction

    // Continuous comparison of both configurations against the model.
    always @(negedge clk) begin
        check("model_a_mask", 32'(s1), exp_mask(N1, D1));
        check("model_a_done", 32'(d1), exp_done(N1, D1));
        check("model_b_mask", 32'(s2), exp_mask(N2, D2));
        check("model_b_done", 32'(d2), exp_done(N2, D2));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] lock_drop_exp;

    initial begin
        rst          = 1'b1;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
        step(3);
        check("rst_mask", 32'(s1), 32'd0);
        check("rst_done", 32'(d1), 32'd0);

        // Basic sequence: pll rises before edge T.
        @(negedge clk) rst = 1'b0;
        @(negedge clk) pll_locked = 1'b1;
        step(6);  check("basic_t5",   32'(s1), 32'b000);
        step(1);  check("basic_t6",   32'(s1), 32'b001);
        step(3);  check("basic_t9",   32'(s1), 32'b001);
        step(1);  check("basic_t10",  32'(s1), 32'b011);
        step(3);  check("basic_t13",  32'(s1), 32'b011);
                  check("basic_t13d", 32'(d1), 32'd0);
        step(1);  check("basic_t14",  32'(s1), 32'b111);
                  check("basic_t14d", 32'(d1), 32'd1);
        step(4);  check("basic_hold", 32'(s1), 32'b111);

        // Lock loss while done.
        pll_locked = 1'b0;
        step(2);  check("lock_drop_2", 32'(s1), 32'b111);
        step(1);
`ifdef RESET_SEQ_LOCK_MONITOR_EN
        lock_drop_exp = 32'd0;
`else
        lock_drop_exp = 32'b1111;
`endif
        check("lock_drop_3", 32'({d1, s1}), lock_drop_exp);
        pll_locked = 1'b1;
        step(5);

        // Async reset mid-count, then a fresh sequence.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(8);  check("pre_async", 32'(s1), 32'b001);
        #3 rst = 1'b1;
        #1;
        check("async_a", 32'({d1, s1}), 32'd0);
        check("async_b", 32'({d2, s2}), 32'd0);
        @(negedge clk) rst = 1'b0;
        step(6);  check("async_t5",  32'(s1), 32'b000);
        step(1);  check("async_t6",  32'(s1), 32'b001);
        step(8);  check("async_t14", 32'({d1, s1}), 32'b1111);

        // Held request keeps everything in reset.
        soft_rst_req = 1'b1;
        step(20); check("held_mask", 32'({d1, s1}), 32'd0);
        soft_rst_req = 1'b0;
        step(4);  check("held_s3",  32'(s1), 32'b000);
        step(1);  check("held_rel", 32'(s1), 32'b001);

        // Soft abort one cycle after stage 1 releases.
        step(4);  check("abort_pre", 32'(s1), 32'b011);
        soft_rst_req = 1'b1;
        step(1);  check("abort_mask", 32'({d1, s1}), 32'd0);
        soft_rst_req = 1'b0;
        step(4);  check("reseq_s3",   32'(s1), 32'b000);
        step(1);  check("reseq_s0",   32'(s1), 32'b001);
        step(8);  check("reseq_done", 32'({d1, s1}), 32'b1111);

        // Abort colliding with the stage-0 terminal count.
        soft_rst_req = 1'b1;
        step(1);  check("coll_abort", 32'(s1), 32'b000);
        soft_rst_req = 1'b0;
        step(4);  check("coll_pre", 32'(s1), 32'b000);
        soft_rst_req = 1'b1;
        step(1);  check("coll_mask", 32'(s1), 32'b000);
        soft_rst_req = 1'b0;
        step(4);  check("coll_hold", 32'(s1), 32'b000);
        step(1);  check("coll_rel",  32'(s1), 32'b001);

        // Random phase; the negedge checker compares against the model.
        for (int i = 0; i < 3000; i++) begin
            soft_rst_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 79) == 0) pll_locked = ~pll_locked;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1;
                check("rand_async_a", 32'({d1, s1}), 32'd0);
                check("rand_async_b", 32'({d2, s2}), 32'd0);
                #3 rst = 1'b0;
            end
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
